// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: merges fetch and data requests onto one downstream port.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants under contention.
module core_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_request_enable,
  input  logic                freq_mode,
  input  logic [ADDR_W-1:0]   freq_addr,
  input  logic [DATA_W-1:0]   freq_wdata,
  input  logic [DATA_W/8-1:0] freq_wstrb,
  output logic                fetch_response_enable,
  output logic [DATA_W-1:0]   fresp_data,
  input  logic                mem_request_enable,
  input  logic                mreq_mode,
  input  logic [ADDR_W-1:0]   mreq_addr,
  input  logic [DATA_W-1:0]   mreq_wdata,
  input  logic [DATA_W/8-1:0] mreq_wstrb,
  output logic                mem_response_enable,
  output logic [DATA_W-1:0]   mresp_data,
  output logic                bus_request_enable,
  output logic                breq_mode,
  output logic [ADDR_W-1:0]   breq_addr,
  output logic [DATA_W-1:0]   breq_wdata,
  output logic [DATA_W/8-1:0] breq_wstrb,
  input  logic                bus_response_enable,
  input  logic [DATA_W-1:0]   bresp_data,
  output logic                protocol_err,
  output logic                timeout_err
);

  localparam int SW = DATA_W / 8;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  logic [0:0]        state;
  logic              owner;
  logic [31:0]       wcnt;

  logic              f_pend, f_busy, f_mode;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_wdata;
  logic [SW-1:0]     f_wstrb;

  logic              m_pend, m_busy, m_mode;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [SW-1:0]     m_wstrb;

  logic              grant_mem, issue, to_hit, fire;
  logic [DATA_W-1:0] fire_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;
`endif

  // Grant selection, issue and completion conditions.
  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    grant_mem = m_pend && (!f_pend || !last_owner);
`else
    grant_mem = m_pend;
`endif
    issue     = (state == IDLE) && (f_pend || m_pend);
    to_hit    = (TIMEOUT > 0) && (wcnt == TO_LAST);
    fire      = (state == WAIT) && (bus_response_enable || to_hit);
    fire_data = bus_response_enable ? bresp_data : '0;
  end

  // Per-channel request capture, busy tracking and drop detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_pend <= 1'b0; f_busy <= 1'b0; f_mode <= 1'b0;
      f_addr <= '0; f_wdata <= '0; f_wstrb <= '0;
      m_pend <= 1'b0; m_busy <= 1'b0; m_mode <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_wstrb <= '0;
      protocol_err <= 1'b0;
    end else begin
      if (issue && !grant_mem) f_pend <= 1'b0;
      if (issue && grant_mem)  m_pend <= 1'b0;
      if (fetch_response_enable) f_busy <= 1'b0;
      if (mem_response_enable)   m_busy <= 1'b0;
      if (fetch_request_enable) begin
        if (!f_busy || fetch_response_enable) begin
          f_pend  <= 1'b1;
          f_busy  <= 1'b1;
          f_mode  <= freq_mode;
          f_addr  <= freq_addr;
          f_wdata <= freq_wdata;
          f_wstrb <= freq_wstrb;
        end else begin
          protocol_err <= 1'b1;
        end
      end
      if (mem_request_enable) begin
        if (!m_busy || mem_response_enable) begin
          m_pend  <= 1'b1;
          m_busy  <= 1'b1;
          m_mode  <= mreq_mode;
          m_addr  <= mreq_addr;
          m_wdata <= mreq_wdata;
          m_wstrb <= mreq_wstrb;
        end else begin
          protocol_err <= 1'b1;
        end
      end
    end
  end

  // Single-outstanding downstream FSM with response routing and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      wcnt  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner <= 1'b1;
`endif
      bus_request_enable    <= 1'b0;
      breq_mode             <= 1'b0;
      breq_addr             <= '0;
      breq_wdata            <= '0;
      breq_wstrb            <= '0;
      fetch_response_enable <= 1'b0;
      fresp_data            <= '0;
      mem_response_enable   <= 1'b0;
      mresp_data            <= '0;
      timeout_err           <= 1'b0;
    end else begin
      bus_request_enable    <= 1'b0;
      fetch_response_enable <= 1'b0;
      mem_response_enable   <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            bus_request_enable <= 1'b1;
            breq_mode  <= grant_mem ? m_mode  : f_mode;
            breq_addr  <= grant_mem ? m_addr  : f_addr;
            breq_wdata <= grant_mem ? m_wdata : f_wdata;
            breq_wstrb <= grant_mem ? m_wstrb : f_wstrb;
            owner <= grant_mem;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= grant_mem;
`endif
            wcnt  <= '0;
            state <= WAIT;
          end
        end
        default: begin
          if (fire) begin
            if (owner) begin
              mem_response_enable <= 1'b1;
              mresp_data <= fire_data;
            end else begin
              fetch_response_enable <= 1'b1;
              fresp_data <= fire_data;
            end
            if (!bus_response_enable) timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed vector table plus hand-written corner cases.
// TIMEOUT is set to 8 so the forced-response path is reachable.
module tb_core_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_request_enable, freq_mode;
  logic [31:0] freq_addr, freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable, mreq_mode;
  logic [31:0] mreq_addr, mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        bus_request_enable, breq_mode;
  logic [31:0] breq_addr, breq_wdata;
  logic [3:0]  breq_wstrb;
  logic        bus_response_enable;
  logic [31:0] bresp_data;
  logic        protocol_err, timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .fetch_request_enable(fetch_request_enable),
    .freq_mode(freq_mode), .freq_addr(freq_addr),
    .freq_wdata(freq_wdata), .freq_wstrb(freq_wstrb),
    .fetch_response_enable(fetch_response_enable),
    .fresp_data(fresp_data),
    .mem_request_enable(mem_request_enable),
    .mreq_mode(mreq_mode), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_wstrb(mreq_wstrb),
    .mem_response_enable(mem_response_enable),
    .mresp_data(mresp_data),
    .bus_request_enable(bus_request_enable),
    .breq_mode(breq_mode), .breq_addr(breq_addr),
    .breq_wdata(breq_wdata), .breq_wstrb(breq_wstrb),
    .bus_response_enable(bus_response_enable),
    .bresp_data(bresp_data),
    .protocol_err(protocol_err), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        freq;
    logic [31:0] faddr;
    logic        mreq;
    logic        mmode;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  mwstrb;
    logic        bre;
    logic [31:0] bdata;
    logic        e_breq;
    logic [31:0] e_addr;
    logic        e_mode;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_fre;
    logic [31:0] e_fdata;
    logic        e_mre;
    logic [31:0] e_mdata;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_request_enable = 1'b0;
    freq_mode = 1'b0; freq_addr = '0; freq_wdata = '0; freq_wstrb = '0;
    mem_request_enable = 1'b0;
    mreq_mode = 1'b0; mreq_addr = '0; mreq_wdata = '0; mreq_wstrb = '0;
    bus_response_enable = 1'b0; bresp_data = '0;
  endtask

  task automatic fetch_req(input logic [31:0] a);
    fetch_request_enable = 1'b1; freq_addr = a;
  endtask

  task automatic mem_req(input logic [31:0] a, input logic m,
                         input logic [31:0] d);
    mem_request_enable = 1'b1; mreq_addr = a; mreq_mode = m;
    mreq_wdata = d; mreq_wstrb = 4'hF;
  endtask

  // Issue of a pending request on the next edge, then its response.
  task automatic serve(input string nm, input logic [31:0] a,
                       input logic is_mem, input logic m,
                       input logic [31:0] rd);
    cyc();
    chk({nm, "_breq_en"}, 32'(bus_request_enable), 32'd1);
    chk({nm, "_breq_addr"}, breq_addr, a);
    chk({nm, "_breq_mode"}, 32'(breq_mode), 32'(m));
    bus_response_enable = 1'b1; bresp_data = rd;
    cyc();
    bus_response_enable = 1'b0; bresp_data = '0;
    chk({nm, "_fresp_en"}, 32'(fetch_response_enable), 32'(!is_mem));
    chk({nm, "_mresp_en"}, 32'(mem_response_enable), 32'(is_mem));
    if (is_mem) chk({nm, "_mresp_data"}, mresp_data, rd);
    else        chk({nm, "_fresp_data"}, fresp_data, rd);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_breq_en"}, 32'(bus_request_enable), 32'd0);
    chk({nm, "_breq_addr"}, breq_addr, 32'd0);
    chk({nm, "_breq_mode"}, 32'(breq_mode), 32'd0);
    chk({nm, "_fresp_en"}, 32'(fetch_response_enable), 32'd0);
    chk({nm, "_fresp_data"}, fresp_data, 32'd0);
    chk({nm, "_mresp_en"}, 32'(mem_response_enable), 32'd0);
    chk({nm, "_mresp_data"}, mresp_data, 32'd0);
    chk({nm, "_perr"}, 32'(protocol_err), 32'd0);
    chk({nm, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    // freq faddr mreq mmode maddr mwdata mwstrb bre bdata |
    // breq addr mode wdata wstrb fre fdata mre mdata
    tbl[0]  = '{1, 32'h1000, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 32'h1000, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h1000, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF,
                0, 32'h1000, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h1000, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tbl[5]  = '{1, 32'h100, 1, 1, 32'h200, 32'h55, 4'hF, 0, 0,
                0, 32'h1000, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 32'h200, 1, 32'h55, 4'hF, 0, 32'hDEADBEEF, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h200, 1, 32'h55, 4'hF, 0, 32'hDEADBEEF, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111,
                0, 32'h200, 1, 32'h55, 4'hF, 0, 32'hDEADBEEF,
                1, 32'h11111111};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                1, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h11111111};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h100, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h11111111};
    tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h22222222,
                0, 32'h100, 0, 0, 0, 1, 32'h22222222, 0, 32'h11111111};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                0, 32'h100, 0, 0, 0, 0, 32'h22222222, 0, 32'h11111111};

    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    chk_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      fetch_request_enable = tbl[i].freq;
      freq_addr            = tbl[i].faddr;
      mem_request_enable   = tbl[i].mreq;
      mreq_mode            = tbl[i].mmode;
      mreq_addr            = tbl[i].maddr;
      mreq_wdata           = tbl[i].mwdata;
      mreq_wstrb           = tbl[i].mwstrb;
      bus_response_enable  = tbl[i].bre;
      bresp_data           = tbl[i].bdata;
      cyc();
      chk($sformatf("v%0d_breq_en", i), 32'(bus_request_enable),
          32'(tbl[i].e_breq));
      chk($sformatf("v%0d_breq_addr", i), breq_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_breq_mode", i), 32'(breq_mode),
          32'(tbl[i].e_mode));
      chk($sformatf("v%0d_breq_wdata", i), breq_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_breq_wstrb", i), 32'(breq_wstrb),
          32'(tbl[i].e_wstrb));
      chk($sformatf("v%0d_fresp_en", i), 32'(fetch_response_enable),
          32'(tbl[i].e_fre));
      chk($sformatf("v%0d_fresp_data", i), fresp_data, tbl[i].e_fdata);
      chk($sformatf("v%0d_mresp_en", i), 32'(mem_response_enable),
          32'(tbl[i].e_mre));
      chk($sformatf("v%0d_mresp_data", i), mresp_data, tbl[i].e_mdata);
    end
    idle_inputs();

    // Request in the same cycle as its channel's response is accepted.
    fetch_req(32'h400);
    cyc();
    idle_inputs();
    cyc();
    chk("acc_issue", 32'(bus_request_enable), 32'd1);
    bus_response_enable = 1'b1; bresp_data = 32'h40;
    cyc();
    idle_inputs();
    chk("acc_resp", 32'(fetch_response_enable), 32'd1);
    fetch_req(32'h404);
    cyc();
    idle_inputs();
    chk("acc_perr", 32'(protocol_err), 32'd0);
    serve("acc2", 32'h404, 1'b0, 1'b0, 32'h44);
    chk("acc_perr2", 32'(protocol_err), 32'd0);

    // Request while busy is dropped and flagged.
    fetch_req(32'h300);
    cyc();
    idle_inputs();
    cyc();
    chk("drop_issue", 32'(bus_request_enable), 32'd1);
    fetch_req(32'h304);
    cyc();
    idle_inputs();
    chk("drop_perr", 32'(protocol_err), 32'd1);
    bus_response_enable = 1'b1; bresp_data = 32'h55;
    cyc();
    idle_inputs();
    chk("drop_resp", 32'(fetch_response_enable), 32'd1);
    cyc();
    chk("drop_noreq1", 32'(bus_request_enable), 32'd0);
    cyc();
    chk("drop_noreq2", 32'(bus_request_enable), 32'd0);
    chk("drop_perr_sticky", 32'(protocol_err), 32'd1);

    // Timeout after 8 WAIT cycles with no response.
    mem_req(32'h500, 1'b0, 32'h0);
    cyc();
    idle_inputs();
    cyc();
    chk("to_issue", 32'(bus_request_enable), 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("to_wait%0d", i), 32'(mem_response_enable), 32'd0);
    end
    cyc();
    chk("to_mresp_en", 32'(mem_response_enable), 32'd1);
    chk("to_mresp_data", mresp_data, 32'd0);
    chk("to_terr", 32'(timeout_err), 32'd1);
    bus_response_enable = 1'b1; bresp_data = 32'h99;
    cyc();
    idle_inputs();
    chk("to_late_m", 32'(mem_response_enable), 32'd0);
    chk("to_late_f", 32'(fetch_response_enable), 32'd0);
    cyc();
    chk("to_late_req", 32'(bus_request_enable), 32'd0);
    chk("to_late_mdata", mresp_data, 32'd0);

    // Reset during WAIT abandons the transaction.
    fetch_req(32'h600);
    cyc();
    idle_inputs();
    cyc();
    chk("rw_issue", 32'(bus_request_enable), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_all_zero("rw_reset");
    bus_response_enable = 1'b1; bresp_data = 32'h77;
    cyc();
    idle_inputs();
    chk("rw_f", 32'(fetch_response_enable), 32'd0);
    chk("rw_m", 32'(mem_response_enable), 32'd0);
    cyc();
    chk("rw_noreq", 32'(bus_request_enable), 32'd0);
    mem_req(32'h700, 1'b1, 32'hAB);
    cyc();
    idle_inputs();
    serve("rw_new", 32'h700, 1'b1, 1'b1, 32'h33);
    chk("rw_wdata", breq_wdata, 32'hAB);

    // Contention ordering, with last owner MEM then FETCH.
    mem_req(32'h800, 1'b0, 32'h0);
    cyc();
    idle_inputs();
    serve("lone_m", 32'h800, 1'b1, 1'b0, 32'h88);
    fetch_req(32'h900);
    mem_req(32'hA00, 1'b0, 32'h0);
    cyc();
    idle_inputs();
`ifdef ARB_ROUND_ROBIN_EN
    serve("c1_first", 32'h900, 1'b0, 1'b0, 32'h90);
    serve("c1_second", 32'hA00, 1'b1, 1'b0, 32'hA0);
`else
    serve("c1_first", 32'hA00, 1'b1, 1'b0, 32'hA0);
    serve("c1_second", 32'h900, 1'b0, 1'b0, 32'h90);
`endif
    fetch_req(32'hB00);
    cyc();
    idle_inputs();
    serve("lone_f", 32'hB00, 1'b0, 1'b0, 32'hB0);
    fetch_req(32'hC00);
    mem_req(32'hD00, 1'b0, 32'h0);
    cyc();
    idle_inputs();
    serve("c2_first", 32'hD00, 1'b1, 1'b0, 32'hD0);
    serve("c2_second", 32'hC00, 1'b0, 1'b0, 32'hC0);
    chk("end_perr", 32'(protocol_err), 32'd0);
    chk("end_terr", 32'(timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Merges the core's two bus request channels (instruction fetch, data memory) onto the single downstream request/response port toward the MMU/memory subsystem.
- Keeps one transaction outstanding downstream at a time, queues at most one request per channel, and routes each response back to the channel that issued it.
- Sits between the core and the MMU; the core-side ports keep the core's existing request/response pulse protocol.

Parameters:
- ADDR_W, 32, address width of all request ports
- DATA_W, 32, data width; strobe width is DATA_W/8
- TIMEOUT, 0, maximum cycles in WAIT before a forced response; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- fetch_request_enable  in  1  one-cycle fetch request pulse
- freq_mode / freq_addr / freq_wdata / freq_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  fetch request payload (mode 1 = write)
- fetch_response_enable  out  1  one-cycle fetch response pulse
- fresp_data  out  DATA_W  fetch response data
- mem_request_enable  in  1  one-cycle data request pulse
- mreq_mode / mreq_addr / mreq_wdata / mreq_wstrb  in  1/ADDR_W/DATA_W/DATA_W/8  data request payload
- mem_response_enable  out  1  one-cycle data response pulse
- mresp_data  out  DATA_W  data response data
- bus_request_enable  out  1  downstream request pulse
- breq_mode / breq_addr / breq_wdata / breq_wstrb  out  1/ADDR_W/DATA_W/DATA_W/8  downstream payload
- bus_response_enable  in  1  downstream response pulse
- bresp_data  in  DATA_W  downstream response data
- protocol_err  out  1  sticky; a request was dropped
- timeout_err  out  1  sticky; a downstream transaction timed out

Behaviour:
- Reset: all outputs 0, both pending/busy flags cleared, state IDLE, wait counter 0, last_owner = MEM. Reset mid-transaction abandons it. A bus_response_enable arriving in IDLE is ignored and raises no error.
- Per channel: a pending register holds mode/addr/wdata/wstrb, plus a busy flag.
  - busy sets when the request is sampled.
  - busy clears on the edge on which that channel's response_enable is high.
- A request sampled while its channel is busy is dropped and sets protocol_err, except in the cycle the channel's response_enable is high; that request is accepted.
- State IDLE:
  - If any pending bit is set, select an owner: MEM wins over FETCH (fixed priority).
  - Register the owner's payload onto breq_*.
  - Assert bus_request_enable for exactly one cycle.
  - Clear that pending bit, record owner and last_owner, and go to WAIT.
- State WAIT:
  - breq_* hold their value.
  - On bus_response_enable: the owner's *_response_enable pulses one cycle later, with resp data = bresp_data registered. Return to IDLE.
- Latency:
  - Request sampled at edge N → bus_request_enable high in the cycle after edge N+1.
  - bus_response_enable at edge M → core response high in the cycle after edge M.
  - Back-to-back issue needs one IDLE cycle between transactions.
- Requests arriving in any state are captured into pending regardless of arbiter state.
- Both channels requesting in the same cycle: both are captured; the winner issues first and the loser issues after the winner's response.
- Timeout (TIMEOUT>0):
  - The wait counter resets on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no response, the owner receives a response pulse with data 0, timeout_err sets, and the state returns to IDLE.
  - A late bus response then arrives in IDLE and is ignored.
- protocol_err and timeout_err clear only on rst.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: when both pending bits are set in IDLE, grant the channel that is not last_owner. A single pending request is granted regardless of last_owner.
- Undefined: fixed MEM-over-FETCH priority, and the last_owner register is not built.

Test Plan:
- Single fetch, addr 0x0000_1000: bus_request_enable 2 cycles later with breq_addr=0x1000, breq_mode=0. bus response 0xDEADBEEF → fetch_response_enable for 1 cycle with fresp_data=0xDEADBEEF; mem_response_enable stays 0.
- Simultaneous fetch 0x100 and mem write 0x200/0x55/wstrb 0xF: mem issues first (breq_mode=1, breq_wstrb=0xF). Fetch issues the cycle after the mem response plus one IDLE cycle.
- ARB_ROUND_ROBIN_EN, last_owner=MEM, both pending: fetch is granted first; on the next contention, mem is granted first.
- Second fetch request while fetch busy: dropped and protocol_err=1, with no extra bus request. A fetch request in the same cycle as fetch_response_enable is accepted and protocol_err stays 0.
- TIMEOUT=8, mem read with no bus response: after 8 WAIT cycles mem_response_enable=1 with mresp_data=0 and timeout_err=1. A later bus response is ignored.
- rst asserted during WAIT: all outputs 0 next cycle. A subsequent bus response produces no core response, and a new request after reset completes normally.
